lcd_char_feeder: RTL and testbench

- Upstream stage of the LCD controller.
- Buffers host bytes in a small FIFO.
- Fires the controller's one-shot `init`, then waits until the controller has finished power-up/config and reached its character-idle state.
- Feeds characters one at a time: a one-cycle `enviar` pulse with a stable `info` byte, then a fixed pacing gap, because the controller exposes no done/ready back to this stage.

---
 rtl/lcd_char_feeder_if.sv | 18 +
 rtl/lcd_char_feeder.sv | 211 +++++++++++++++++++++
 tb/tb_lcd_char_feeder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_char_feeder_if.sv
// Host-side byte write channel into the LCD character feeder.
interface lcd_char_feeder_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/lcd_char_feeder.sv
// LCD character feeder: buffers host bytes, brings the LCD controller up with a
// one-shot init, then paces characters out with a fixed gap after each enviar
// pulse, because the controller gives no completion indication back.
module lcd_char_feeder #(
  parameter int DEPTH          = 16,
  parameter int AW             = 4,
  parameter int STARTUP_CYCLES = 2000000,
  parameter int CHAR_GAP       = 4000,
  parameter int MAX_CHARS      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  lcd_char_feeder_if.slave   wr,
  output logic               lcd_init,
  output logic               lcd_enviar,
  output logic [7:0]         lcd_info,
  output logic               lcd_up,
  output logic [5:0]         char_count,
  output logic               dropped,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BOOT,
    S_READY,
    S_SEND,
    S_GAP
  } state_t;

  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [31:0] BOOT_LAST = 32'(STARTUP_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(CHAR_GAP - 1);
  localparam logic [5:0]  MAX_C     = 6'(MAX_CHARS);

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          push;
  logic          pop;
  logic          empty;
  logic [7:0]    head;

  // wr_ready comes from the registered full flag, so a pop never frees a slot
  // for a write in the same cycle.
  assign wr.wr_ready = !full_q;
  assign push        = wr.wr_valid && !full_q;
  assign empty       = (cnt_q == '0);
  assign head        = mem_q[rd_ptr_q];

  // Pointer, occupancy and full-flag update for push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d = (cnt_d == DEPTH_C);
  end

  // Storage array; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr.wr_data;
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [31:0] wait_q, wait_d;
  logic [7:0]  lcd_info_q, lcd_info_d;
  logic        lcd_up_q, lcd_up_d;
  logic [5:0]  char_count_q, char_count_d;
  logic        dropped_q, dropped_d;
  logic        room;

  assign room = (char_count_q < MAX_C);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start only matters in S_IDLE, so bring-up happens once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_START;
      S_START: state_d = S_BOOT;
      S_BOOT:  if (wait_q == BOOT_LAST) state_d = S_READY;
      S_READY: if (!empty && room) state_d = S_SEND;
      S_SEND:  state_d = S_GAP;
      S_GAP:   if (wait_q == GAP_LAST) state_d = S_READY;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath updates decoded from the current state.
  always_comb begin
    lcd_init     = 1'b0;
    lcd_enviar   = 1'b0;
    pop          = 1'b0;
    wait_d       = wait_q;
    lcd_info_d   = lcd_info_q;
    lcd_up_d     = lcd_up_q;
    char_count_d = char_count_q;
    dropped_d    = dropped_q;
    busy         = !((state_q == S_IDLE) || ((state_q == S_READY) && empty));
    case (state_q)
      S_START: begin
        lcd_init = 1'b1;
        wait_d   = '0;
      end
      S_BOOT: begin
        if (wait_q == BOOT_LAST) begin
          lcd_up_d = 1'b1;
          wait_d   = '0;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_READY: begin
        if (!empty) begin
          pop = 1'b1;
          // Past the character limit the byte is drained without reaching the LCD.
          if (room) begin
            lcd_info_d = head;
          end else begin
            dropped_d = 1'b1;
          end
        end
      end
      S_SEND: begin
        lcd_enviar = 1'b1;
        wait_d     = '0;
        if (room) begin
          char_count_d = char_count_q + 6'd1;
        end
      end
      S_GAP: begin
        if (wait_q == GAP_LAST) begin
          wait_d = '0;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; lcd_info only changes on a pop so it is stable for the
  // whole send and gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q       <= '0;
      lcd_info_q   <= 8'h00;
      lcd_up_q     <= 1'b0;
      char_count_q <= '0;
      dropped_q    <= 1'b0;
    end else begin
      wait_q       <= wait_d;
      lcd_info_q   <= lcd_info_d;
      lcd_up_q     <= lcd_up_d;
      char_count_q <= char_count_d;
      dropped_q    <= dropped_d;
    end
  end

  assign lcd_info   = lcd_info_q;
  assign lcd_up     = lcd_up_q;
  assign char_count = char_count_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_lcd_char_feeder.sv
// Directed bench for lcd_char_feeder with short startup/gap and a 4-char limit.
module tb_lcd_char_feeder;
  localparam int STARTUP = 100;
  localparam int GAP     = 10;
  localparam int MAXC    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       lcd_init, lcd_enviar, lcd_up, dropped, busy;
  logic [7:0] lcd_info;
  logic [5:0] char_count;

  int tests = 0;
  int fails = 0;

  lcd_char_feeder_if wr_if ();

  lcd_char_feeder #(
    .DEPTH(16), .AW(4), .STARTUP_CYCLES(STARTUP), .CHAR_GAP(GAP), .MAX_CHARS(MAXC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .wr(wr_if.slave),
    .lcd_init(lcd_init), .lcd_enviar(lcd_enviar), .lcd_info(lcd_info),
    .lcd_up(lcd_up), .char_count(char_count), .dropped(dropped), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] din;
    bit         sent;
    int         gap;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = b;
    step();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    start = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 8'h00;
    step();
    step();
    check("rst_wr_ready", wr_if.wr_ready, 1);
    check("rst_init_enviar", {lcd_init, lcd_enviar}, 0);
    check("rst_info", lcd_info, 8'h00);
    check("rst_up_cnt_drop", {lcd_up, char_count, dropped}, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    step();
  endtask

  // Returns at the first negedge where lcd_up is seen high (state S_READY).
  task automatic bring_up;
    int n;
    int inits;
    int envs;
    start = 1'b1;
    step();
    start = 1'b0;
    check("init_pulse", lcd_init, 1);
    check("busy_start", busy, 1);
    inits = 1;
    envs  = 0;
    n     = 0;
    while (!lcd_up && n < 500) begin
      step();
      n++;
      if (lcd_init) inits++;
      if (lcd_enviar) envs++;
    end
    check("up_latency", n, STARTUP + 1);
    check("init_count", inits, 1);
    check("boot_enviar", envs, 0);
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!lcd_enviar && n < 300);
    check("pulse_seen", lcd_enviar, 1);
  endtask

  initial begin
    int n;
    int bad;
    int pulses;

    vt[0] = '{8'h48, 1'b1, 1};
    vt[1] = '{8'h4F, 1'b1, GAP + 2};
    vt[2] = '{8'h4C, 1'b1, GAP + 2};
    vt[3] = '{8'h41, 1'b1, GAP + 2};
    vt[4] = '{8'h21, 1'b0, 0};
    vt[5] = '{8'h3F, 1'b0, 0};

    // Bring-up then a single character.
    do_reset();
    bring_up();
    write_byte(8'h41);
    check("single_no_early_pulse", lcd_enviar, 0);
    step();
    check("single_pulse", lcd_enviar, 1);
    check("single_info", lcd_info, 8'h41);
    step();
    check("single_pulse_width", lcd_enviar, 0);
    check("single_count", char_count, 1);
    bad = 0;
    for (int k = 0; k < GAP; k++) begin
      if (lcd_info !== 8'h41 || lcd_enviar !== 1'b0) bad++;
      step();
    end
    check("single_info_held", bad, 0);
    check("single_busy_fall", busy, 0);

    // Early writes, pacing and saturation from the vector table.
    do_reset();
    for (int i = 0; i < 6; i++) write_byte(vt[i].din);
    check("early_idle_not_busy", busy, 0);
    bring_up();
    for (int i = 0; i < 6; i++) begin
      if (vt[i].sent) begin
        wait_pulse(n);
        check($sformatf("vec%0d_spacing", i), n, vt[i].gap);
        check($sformatf("vec%0d_info", i), lcd_info, vt[i].din);
        check($sformatf("vec%0d_count", i), char_count, i);
        if (i == 3) check("drop_before_limit", dropped, 0);
      end
    end
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (lcd_enviar) pulses++;
    end
    check("sat_extra_pulses", pulses, 0);
    check("sat_count", char_count, MAXC);
    check("sat_dropped", dropped, 1);
    check("sat_info_kept", lcd_info, 8'h41);
    check("sat_busy", busy, 0);

    // Full FIFO before start: 16 accepted, 17th refused.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      check($sformatf("full_ready%0d", i), wr_if.wr_ready, (i < 16) ? 1 : 0);
      write_byte((i < 16) ? (8'h30 + 8'(i)) : 8'hEE);
    end
    bring_up();
    check("full_ready_at_pop", wr_if.wr_ready, 0);
    step();
    check("full_ready_after_pop", wr_if.wr_ready, 1);
    check("full_first_pulse", lcd_enviar, 1);
    check("full_first_info", lcd_info, 8'h30);

    // Reset in the middle of a gap, with the FIFO full again.
    step();
    write_byte(8'h55);
    check("gap_refill_full", wr_if.wr_ready, 0);
    step();
    reset = 1'b0;
    #1;
    check("midrst_enviar", lcd_enviar, 0);
    check("midrst_info", lcd_info, 8'h00);
    check("midrst_up", lcd_up, 0);
    check("midrst_ready", wr_if.wr_ready, 1);
    check("midrst_count", char_count, 0);
    step();
    reset = 1'b1;
    step();
    bring_up();
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (lcd_enviar) pulses++;
    end
    check("rerun_fifo_lost", pulses, 0);
    check("rerun_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
